// File: rtl/seg7_scan_driver_if.sv
// Bundle between the glyph-word source and the four-digit seven-segment scan driver.
// The master supplies the glyph word and controls; the slave drives the anode/segment pins.
interface seg7_scan_driver_if;
    logic [15:0] word_in;
    logic        load;
    logic        en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_tick;

    modport master (
        output word_in, load, en,
        input  an, seg, frame_tick
    );

    modport slave (
        input  word_in, load, en,
        output an, seg, frame_tick
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver: latches a 16-bit glyph word and scans
// digits 0..3, each slot ending in one dark guard cycle to suppress ghosting.
module seg7_scan_driver #(
    parameter int DIV_WIDTH  = 16,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_driver_if.slave bus
);

    localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [DIV_WIDTH-1:0] r_p;
    logic [1:0]           r_idx;
    logic [15:0]          r_disp;
    logic [3:0]           r_an;
    logic [6:0]           r_seg;
    logic                 r_frame_tick;

    logic                 w_pmax;
    logic                 w_lit;
    logic [3:0]           w_nib;
    logic [3:0]           w_an_raw;
    logic [6:0]           w_seg_raw;

    // Glyph codes map to letter shapes, bit order {g,f,e,d,c,b,a}; unused codes are blank.
    function automatic logic [6:0] glyph(input logic [3:0] code);
        case (code)
            4'd0:    glyph = 7'h77;
            4'd1:    glyph = 7'h7C;
            4'd2:    glyph = 7'h5E;
            4'd3:    glyph = 7'h79;
            4'd4:    glyph = 7'h37;
            4'd5:    glyph = 7'h07;
            4'd8:    glyph = 7'h6D;
            4'd9:    glyph = 7'h3E;
            4'd10:   glyph = 7'h1C;
            4'd12:   glyph = 7'h30;
            default: glyph = 7'h00;
        endcase
    endfunction

    assign w_pmax = &r_p;
    assign w_lit  = bus.en && !w_pmax;

    always_comb begin
        w_nib = r_disp[3:0];
        case (r_idx)
            2'd0: w_nib = r_disp[3:0];
            2'd1: w_nib = r_disp[7:4];
            2'd2: w_nib = r_disp[11:8];
            2'd3: w_nib = r_disp[15:12];
            default: w_nib = r_disp[3:0];
        endcase
    end

    // The last prescaler count of each slot is the dark guard cycle.
    assign w_an_raw  = w_lit ? (4'b0001 << r_idx) : 4'h0;
    assign w_seg_raw = w_lit ? glyph(w_nib) : 7'h00;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p          <= '0;
            r_idx        <= 2'd0;
            r_disp       <= 16'hFFFF;
            r_an         <= AN_OFF;
            r_seg        <= SEG_OFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_p          <= r_p + 1'b1;
            if (w_pmax)
                r_idx    <= r_idx + 2'd1;
            if (bus.load)
                r_disp   <= bus.word_in;
            r_an         <= ACTIVE_LOW ? ~w_an_raw  : w_an_raw;
            r_seg        <= ACTIVE_LOW ? ~w_seg_raw : w_seg_raw;
            r_frame_tick <= w_pmax && (r_idx == 2'd3);
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIV_WIDTH=2, active-low pins) against a
// cycle-count reference model: slot position is derived from clocks elapsed since reset.
module tb_seg7_scan_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(.DIV_WIDTH(2), .ACTIVE_LOW(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] gtab [16] = '{7'h77, 7'h7C, 7'h5E, 7'h79, 7'h37, 7'h07, 7'h00, 7'h00,
                              7'h6D, 7'h3E, 7'h1C, 7'h00, 7'h30, 7'h00, 7'h00, 7'h00};

    // Model state: clocks since reset release and the latched glyph word.
    int unsigned m_t    = 0;
    logic [15:0] m_disp = 16'hFFFF;

    function automatic int unsigned m_phase(input int unsigned t);
        return t % 4;
    endfunction

    function automatic int unsigned m_digit(input int unsigned t);
        return (t / 4) % 4;
    endfunction

    task automatic check_out(input string tag, input logic [3:0] ea, input logic [6:0] es,
                             input logic ef);
        checks++;
        assert (bus.an === ea) else begin
            errors++;
            $error("FAIL %s an: observed %b expected %b", tag, bus.an, ea);
        end
        checks++;
        assert (bus.seg === es) else begin
            errors++;
            $error("FAIL %s seg: observed %h expected %h", tag, bus.seg, es);
        end
        checks++;
        assert (bus.frame_tick === ef) else begin
            errors++;
            $error("FAIL %s frame_tick: observed %b expected %b", tag, bus.frame_tick, ef);
        end
    endtask

    // One clock: predict pins from pre-edge state and inputs, clock, update model, check.
    task automatic step(input string tag);
        logic [3:0] ea;
        logic [6:0] es;
        logic       ef;
        int unsigned ph, dg;
        if (rst) begin
            ea = 4'hF; es = 7'h7F; ef = 1'b0;
        end else begin
            ph = m_phase(m_t);
            dg = m_digit(m_t);
            if (bus.en && ph != 3) begin
                ea = ~(4'b0001 << dg);
                es = ~gtab[m_disp[dg*4 +: 4]];
            end else begin
                ea = 4'hF;
                es = 7'h7F;
            end
            ef = (ph == 3) && (dg == 3);
        end
        @(posedge clk);
        if (rst) begin
            m_t = 0;
            m_disp = 16'hFFFF;
        end else begin
            m_t++;
            if (bus.load) m_disp = bus.word_in;
        end
        #1;
        check_out(tag, ea, es, ef);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Advance (bounded) until the model is in the given digit slot at the given phase.
    task automatic seek(input string tag, input int unsigned dg, input int unsigned ph);
        int k;
        k = 0;
        while (!(m_digit(m_t) == dg && m_phase(m_t) == ph) && k < 32) begin
            step(tag);
            k++;
        end
        checks++;
        assert (k < 32) else begin
            errors++;
            $error("FAIL %s seek: observed %0d steps required <32", tag, k);
        end
    endtask

    int ft_count;

    initial begin
        bus.word_in = 16'h0000;
        bus.load    = 1'b0;
        bus.en      = 1'b1;
        rst         = 1'b1;
        run("reset", 3);

        // Blank scan after reset: anodes cycle, segments stay dark.
        rst = 1'b0;
        run("blank_scan", 20);

        // SAVE
        bus.word_in = 16'h80A3;
        bus.load    = 1'b1;
        step("load_save");
        bus.load    = 1'b0;
        run("save_scan", 20);

        // _ADD loaded in the middle of the digit-1 slot.
        seek("seek_d1", 1, 1);
        bus.word_in = 16'hF022;
        bus.load    = 1'b1;
        step("load_add");
        bus.load    = 1'b0;
        run("add_scan", 20);

        // Enable dropped for 10 cycles; scan phase must keep running.
        bus.en = 1'b0;
        run("en_off", 10);
        bus.en = 1'b1;
        run("en_on", 12);

        // Load on the guard cycle that advances to the next digit.
        seek("seek_guard", 2, 3);
        bus.word_in = 16'h9C45;
        bus.load    = 1'b1;
        step("load_adv");
        bus.load    = 1'b0;
        run("adv_scan", 8);

        // frame_tick count over 64 cycles.
        ft_count = 0;
        for (int i = 0; i < 64; i++) begin
            step("ft_run");
            if (bus.frame_tick) ft_count++;
        end
        checks++;
        assert (ft_count === 4) else begin
            errors++;
            $error("FAIL ft_count: observed %0d expected 4", ft_count);
        end

        // Reset while digit 2 is lit with load high.
        seek("seek_d2", 2, 1);
        rst         = 1'b1;
        bus.load    = 1'b1;
        bus.word_in = 16'h0123;
        step("mid_reset");
        rst         = 1'b0;
        bus.load    = 1'b0;
        run("post_reset", 10);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bus.word_in = 16'($urandom);
            bus.load    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) bus.en = ~bus.en;
            rst         = ($urandom_range(0, 79) == 0);
            step("random");
        end
        rst      = 1'b0;
        bus.load = 1'b0;
        bus.en   = 1'b1;
        run("tail", 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
